// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle controller: opcodes, ALU
// encodings, FSM states and 16-bit instruction field positions.
package cpu_pkg;

    localparam int IWIDTH = 16;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int RS_HI    = 11;
    localparam int RS_LO    = 9;
    localparam int RT_HI    = 8;
    localparam int RT_LO    = 6;
    localparam int RD_HI    = 5;
    localparam int RD_LO    = 3;
    localparam int FUNCT_HI = 2;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 5;
    localparam int IMM_LO   = 0;
    localparam int JTGT_HI  = 11;
    localparam int JTGT_LO  = 0;

    typedef enum logic [3:0] {
        OP_R    = 4'b0000,
        OP_LW   = 4'b1000,
        OP_SW   = 4'b1010,
        OP_BEQ  = 4'b0100,
        OP_ADDI = 4'b1100,
        OP_J    = 4'b0010
    } opcode_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    // Observability bundle: FSM state, latched IR and the branch decision
    // the datapath will form from branch & zero.
    typedef struct packed {
        state_t              state;
        logic [IWIDTH-1:0]   ir;
        logic                pcsrc;
    } dbg_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> instruction memory / datapath / data memory signal bundle.
interface multicycle_ctrl_if;
    import cpu_pkg::*;

    // mem_ready is the completion half of the data-memory handshake: the
    // controller holds memread/memwrite high in MEM and an access finishes
    // on the first rising edge where both the strobe and mem_ready are 1.
    logic [IWIDTH-1:0] instr;
    logic              zero;
    logic              mem_ready;
    logic              pcwrite;
    logic              memtoreg;
    logic              branch;
    logic              alusrc;
    logic              regdst;
    logic              regwrite;
    logic              jump;
    logic [3:0]        alucontrol;
    logic              memread;
    logic              memwrite;
    logic              illegal;

    modport master (
        output instr, zero, mem_ready,
        input  pcwrite, memtoreg, branch, alusrc, regdst, regwrite, jump,
               alucontrol, memread, memwrite, illegal
    );

    modport slave (
        input  instr, zero, mem_ready,
        output pcwrite, memtoreg, branch, alusrc, regdst, regwrite, jump,
               alucontrol, memread, memwrite, illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct -> alucontrol map with an undefined-funct flag.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_funct,
    output logic [3:0] o_alucontrol,
    output logic       o_bad_funct
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        o_bad_funct  = 1'b0;
        case (i_opcode)
            OP_R: begin
                if (i_funct > 3'd5) begin
                    o_bad_funct = 1'b1;
                end else begin
                    o_alucontrol = {1'b0, i_funct};
                end
            end
            OP_BEQ:  o_alucontrol = ALU_SUB;
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with registered Moore outputs.
// Optional MEM wait states on mem_ready when MULTICYCLE_CTRL_MEMWAIT_EN is defined.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.slave    bus,
    output dbg_t                o_dbg
);

    state_t            r_state;
    logic [IWIDTH-1:0] r_ir;
    logic              r_pcwrite;
    logic              r_memtoreg;
    logic              r_branch;
    logic              r_alusrc;
    logic              r_regdst;
    logic              r_regwrite;
    logic              r_jump;
    logic [3:0]        r_alucontrol;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_illegal;

    // Outputs are registered, so the word being decoded is the incoming one
    // while in FETCH and the latched IR everywhere else.
    logic [IWIDTH-1:0] w_dec_word;
    logic [3:0]        w_dec_op;
    logic [3:0]        w_ir_op;
    logic [3:0]        w_alucontrol;
    logic              w_bad_funct;
    logic              w_illegal_instr;
    logic              w_mem_go;
    logic              w_sw_pc;

    assign w_dec_word      = (r_state == S_FETCH) ? bus.instr : r_ir;
    assign w_dec_op        = w_dec_word[OPC_HI:OPC_LO];
    assign w_ir_op         = r_ir[OPC_HI:OPC_LO];
    assign w_illegal_instr = ~is_legal_op(w_dec_op) | w_bad_funct;

    alu_decoder u_alu_decoder (
        .i_opcode     (w_dec_op),
        .i_funct      (w_dec_word[FUNCT_HI:FUNCT_LO]),
        .o_alucontrol (w_alucontrol),
        .o_bad_funct  (w_bad_funct)
    );

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    // The SW pcwrite must land in the very cycle mem_ready arrives, which a
    // registered output cannot know in advance, so it is gated live here.
    assign w_mem_go = bus.mem_ready;
    assign w_sw_pc  = (r_state == S_MEM) & r_memwrite & bus.mem_ready;
`else
    assign w_mem_go = 1'b1;
    assign w_sw_pc  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_pcwrite    <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_branch     <= 1'b0;
            r_alusrc     <= 1'b0;
            r_regdst     <= 1'b0;
            r_regwrite   <= 1'b0;
            r_jump       <= 1'b0;
            r_alucontrol <= ALU_ADD;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_pcwrite  <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_regwrite <= 1'b0;
            r_jump     <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_ir    <= bus.instr;
                    r_state <= S_DECODE;
                    if (w_dec_op == OP_J) begin
                        r_jump    <= 1'b1;
                        r_pcwrite <= 1'b1;
                    end else if (w_illegal_instr) begin
                        r_illegal <= 1'b1;
                        r_pcwrite <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if ((w_ir_op == OP_J) || w_illegal_instr) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state      <= S_EXEC;
                        r_alusrc     <= (w_ir_op == OP_LW) || (w_ir_op == OP_SW) ||
                                        (w_ir_op == OP_ADDI);
                        r_regdst     <= (w_ir_op == OP_R);
                        r_alucontrol <= w_alucontrol;
                        if (w_ir_op == OP_BEQ) begin
                            r_branch  <= 1'b1;
                            r_pcwrite <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    case (w_ir_op)
                        OP_R, OP_ADDI: begin
                            r_state    <= S_WB;
                            r_regwrite <= 1'b1;
                            r_pcwrite  <= 1'b1;
                        end
                        OP_LW: begin
                            r_state   <= S_MEM;
                            r_memread <= 1'b1;
                        end
                        OP_SW: begin
                            r_state    <= S_MEM;
                            r_memwrite <= 1'b1;
`ifndef MULTICYCLE_CTRL_MEMWAIT_EN
                            r_pcwrite  <= 1'b1;
`endif
                        end
                        default: begin
                            r_state      <= S_FETCH;
                            r_alusrc     <= 1'b0;
                            r_regdst     <= 1'b0;
                            r_alucontrol <= ALU_ADD;
                        end
                    endcase
                end
                S_MEM: begin
                    if (!w_mem_go) begin
                        r_memread  <= r_memread;
                        r_memwrite <= r_memwrite;
                    end else if (w_ir_op == OP_LW) begin
                        r_state    <= S_WB;
                        r_regwrite <= 1'b1;
                        r_memtoreg <= 1'b1;
                        r_pcwrite  <= 1'b1;
                    end else begin
                        r_state      <= S_FETCH;
                        r_alusrc     <= 1'b0;
                        r_regdst     <= 1'b0;
                        r_alucontrol <= ALU_ADD;
                    end
                end
                default: begin
                    r_state      <= S_FETCH;
                    r_alusrc     <= 1'b0;
                    r_regdst     <= 1'b0;
                    r_alucontrol <= ALU_ADD;
                end
            endcase
        end
    end

    assign bus.pcwrite    = r_pcwrite | w_sw_pc;
    assign bus.memtoreg   = r_memtoreg;
    assign bus.branch     = r_branch;
    assign bus.alusrc     = r_alusrc;
    assign bus.regdst     = r_regdst;
    assign bus.regwrite   = r_regwrite;
    assign bus.jump       = r_jump;
    assign bus.alucontrol = r_alucontrol;
    assign bus.memread    = r_memread;
    assign bus.memwrite   = r_memwrite;
    assign bus.illegal    = r_illegal;

    assign o_dbg.state = r_state;
    assign o_dbg.ir    = r_ir;
    assign o_dbg.pcsrc = r_branch & bus.zero;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, corner sequences and
// random instruction streams against a per-instruction cycle-trace model.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    dbg_t dbg;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .o_dbg (dbg)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];
    bit          mr_q[$];
    logic        model_illegal;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          key;
        logic [13:0] kexp;
    } vec_t;

    vec_t tbl[13];

    localparam logic [15:0] I_ADDI = 16'b1100_001_000_000001;
    localparam logic [15:0] I_SUB  = 16'b0000_001_010_011_001;
    localparam logic [15:0] I_LW   = 16'b1000_001_010_000100;
    localparam logic [15:0] I_SW   = 16'b1010_001_010_000100;
    localparam logic [15:0] I_BEQ  = 16'b0100_001_010_000011;
    localparam logic [15:0] I_J    = 16'b0010_000000101010;
    localparam logic [15:0] I_BAD  = 16'hF123;

    // Vector bits: pcwrite memtoreg branch alusrc regdst regwrite jump alucontrol[4] memread memwrite illegal
    function automatic logic [13:0] mk(input int pc, input int mtr, input int br, input int as,
                                       input int rd, input int rw, input int j, input int alu,
                                       input int mr, input int mw, input int il);
        logic [13:0] v;
        v = {pc[0], mtr[0], br[0], as[0], rd[0], rw[0], j[0], alu[3:0], mr[0], mw[0], il[0]};
        return v;
    endfunction

    function automatic logic [13:0] sample();
        return {bus.pcwrite, bus.memtoreg, bus.branch, bus.alusrc, bus.regdst, bus.regwrite,
                bus.jump, bus.alucontrol, bus.memread, bus.memwrite, bus.illegal};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.instr = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        model_illegal = 1'b0;
    endtask

    // Drives one instruction for n cycles starting in its FETCH cycle; instr
    // is garbage after the first cycle to prove it is only sampled once.
    task automatic run_instr(input logic [15:0] ins, input int n);
        got_q = {};
        for (int c = 0; c < n; c++) begin
            bus.instr = (c == 0) ? ins : 16'($urandom);
            bus.zero  = 1'($urandom);
            if (mr_q.size() > 0) bus.mem_ready = mr_q.pop_front();
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
            else bus.mem_ready = 1'b1;
`else
            else bus.mem_ready = 1'($urandom);
`endif
            #1;
            got_q.push_back(sample());
            @(negedge clk);
        end
    endtask

    // Expected per-cycle outputs of one instruction, FETCH cycle first.
    task automatic build_expected(input logic [15:0] ins);
        logic [3:0] op;
        int f, alu, as, rd, il;
        logic legal;
        op = ins[15:12];
        f  = int'(ins[2:0]);
        legal = (op == 4'b0000 || op == 4'b1000 || op == 4'b1010 || op == 4'b0100 ||
                 op == 4'b1100 || op == 4'b0010) && !(op == 4'b0000 && f > 5);
        il = int'(model_illegal);
        exp_q = {};
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, il));
        if (!legal) begin
            model_illegal = 1'b1;
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else if (op == 4'b0010) begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, il));
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, il));
            alu = (op == 4'b0000) ? f : ((op == 4'b0100) ? 1 : 0);
            as  = (op == 4'b1000 || op == 4'b1010 || op == 4'b1100) ? 1 : 0;
            rd  = (op == 4'b0000) ? 1 : 0;
            if (op == 4'b0100) begin
                exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, il));
            end else begin
                exp_q.push_back(mk(0, 0, 0, as, rd, 0, 0, alu, 0, 0, il));
                if (op == 4'b1000) begin
                    exp_q.push_back(mk(0, 0, 0, as, rd, 0, 0, alu, 1, 0, il));
                    exp_q.push_back(mk(1, 1, 0, as, rd, 1, 0, alu, 0, 0, il));
                end else if (op == 4'b1010) begin
                    exp_q.push_back(mk(1, 0, 0, as, rd, 0, 0, alu, 0, 1, il));
                end else begin
                    exp_q.push_back(mk(1, 0, 0, as, rd, 1, 0, alu, 0, 0, il));
                end
            end
        end
    endtask

    task automatic compare_trace(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_c%0d", name, i + 1), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ins;
        logic [3:0]  ops[6];
        logic [13:0] v;
        int          lat;

        tbl[0]  = '{I_ADDI, 4, 3, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{I_ADDI, 4, 4, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[2]  = '{I_SUB,  4, 3, mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0)};
        tbl[3]  = '{I_SUB,  4, 4, mk(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0)};
        tbl[4]  = '{I_LW,   5, 4, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        tbl[5]  = '{I_LW,   5, 5, mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{I_SW,   4, 4, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[7]  = '{I_BEQ,  3, 3, mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[8]  = '{I_J,    2, 2, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
        tbl[9]  = '{I_BAD,  2, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[10] = '{16'b0000_001_010_011_111, 2, 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[11] = '{16'b0000_001_010_011_101, 4, 3, mk(0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 0)};
        tbl[12] = '{16'b0000_001_010_011_010, 4, 3, mk(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0)};

        do_reset();
        check("reset_state", sample(), 14'd0);

        for (int t = 0; t < 13; t++) begin
            do_reset();
            run_instr(tbl[t].instr, tbl[t].lat);
            lat = -1;
            for (int i = got_q.size() - 1; i >= 0; i--) begin
                v = got_q[i];
                if (v[13]) lat = i + 1;
            end
            check_int($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
            check($sformatf("tbl%0d_key_c%0d", t, tbl[t].key), got_q[tbl[t].key - 1], tbl[t].kexp);
        end

        // Sticky illegal across a legal ADDI, cleared only by reset.
        do_reset();
        build_expected(I_BAD);
        run_instr(I_BAD, exp_q.size());
        compare_trace("illegal_op");
        build_expected(I_ADDI);
        run_instr(I_ADDI, exp_q.size());
        compare_trace("sticky_addi");
        do_reset();
        check("illegal_cleared", sample(), 14'd0);

        // Reset asserted while LW sits in MEM.
        do_reset();
        run_instr(I_LW, 3);
        check("lw_mem_before_rst", sample(), mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", sample(), 14'd0);
        model_illegal = 1'b0;
        build_expected(I_ADDI);
        run_instr(I_ADDI, exp_q.size());
        compare_trace("after_mid_rst");

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
        do_reset();
        build_expected(I_LW);
        for (int k = 0; k < 3; k++) exp_q.insert(3, exp_q[3]);
        mr_q = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_instr(I_LW, exp_q.size());
        compare_trace("lw_wait");
        build_expected(I_SW);
        v = exp_q[3];
        v[13] = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.insert(3, v);
        mr_q = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(I_SW, exp_q.size());
        compare_trace("sw_wait");
`else
        do_reset();
        build_expected(I_LW);
        mr_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_instr(I_LW, exp_q.size());
        compare_trace("lw_no_wait");
        build_expected(I_SW);
        mr_q = {1'b0, 1'b0, 1'b0, 1'b0};
        run_instr(I_SW, exp_q.size());
        compare_trace("sw_no_wait");
`endif

        // Random instruction stream, mostly legal opcodes.
        ops = '{4'b0000, 4'b1000, 4'b1010, 4'b0100, 4'b1100, 4'b0010};
        do_reset();
        for (int r = 0; r < 40; r++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 7) != 0) ins[15:12] = ops[$urandom_range(0, 5)];
            build_expected(ins);
            run_instr(ins, exp_q.size());
            compare_trace($sformatf("rand%0d_%h", r, ins));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit driving the datapath's control inputs (`memtoreg`, `branch`, `alusrc`, `regdst`, `regwrite`, `jump`, `alucontrol`) from the 16-bit instruction word and the datapath's `zero` flag. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, issues single-cycle write strobes to the register file, data memory and PC, and optionally stalls on a data-memory ready handshake. It sits between instruction memory and the datapath at CPU top level.

## Interface
- `IWIDTH`, 16, instruction width; the field layout below assumes exactly 16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `instr`  in  IWIDTH  instruction word from instruction memory; sampled in FETCH.
- `zero`  in  1  ALU zero flag from the datapath.
- `mem_ready`  in  1  data-memory access complete; only used with `MULTICYCLE_CTRL_MEMWAIT_EN`.
- `pcwrite`  out  1  advance or redirect the PC this cycle.
- `memtoreg`, `branch`, `alusrc`, `regdst`, `regwrite`, `jump`  out  1 each  datapath controls.
- `alucontrol`  out  4  ALU operation.
- `memread`, `memwrite`  out  1 each  data-memory strobes.
- `illegal`  out  1  sticky flag: an undefined opcode or funct was decoded.

## Operation
- Fields: opcode `[15:12]`, rs `[11:9]`, rt `[8:6]`, rd `[5:3]`, funct `[2:0]`, imm `[5:0]`, jump target `[11:0]`.
- Opcodes:
  - 0000 R-type
  - 1000 LW
  - 1010 SW
  - 0100 BEQ
  - 1100 ADDI
  - 0010 J
- All other opcodes are illegal.
- alucontrol encodings: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT, 0101 XOR.
- R-type funct 000–101 maps to alucontrol 0000–0101 in the same order; funct 110 and 111 are illegal.
- FETCH: latch `instr` into the internal IR, then go to DECODE.
- DECODE:
  - J: assert `jump` and `pcwrite`, then FETCH.
  - Illegal: set `illegal`, assert `pcwrite` (skip the instruction), then FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: `regdst`=1, `alusrc`=0, alucontrol from funct, then WB.
  - ADDI: `alusrc`=1, ADD, then WB.
  - LW/SW: `alusrc`=1, ADD, then MEM.
  - BEQ: `alusrc`=0, SUB, `branch`=1, `pcwrite`=1, then FETCH. The datapath forms pcsrc = branch & zero.
- MEM:
  - LW: `memread`=1, then WB.
  - SW: `memwrite`=1, `pcwrite`=1, then FETCH.
- WB:
  - `regwrite`=1, `pcwrite`=1, then FETCH.
  - `memtoreg`=1 for LW only; `regdst`=1 for R-type only.
- All outputs are Moore-decoded from state + IR, except `alucontrol`, `alusrc` and `regdst`. Those three hold their EXEC values through MEM and WB of the same instruction so the ALU result stays stable.
- `illegal` clears only on reset.

## Timing
- Reset: state FETCH, IR=0, `illegal`=0. Every output is 0 in the cycle after reset is sampled high.
- Latency in cycles, FETCH through the `pcwrite` cycle:
  - J: 2
  - illegal: 2
  - BEQ: 3
  - R-type: 4
  - ADDI: 4
  - SW: 4
  - LW: 5
- `pcwrite`, `regwrite`, `memwrite` and `memread` are each high for exactly one cycle per instruction; MEM wait states are the only exception.
- `instr` is sampled only on the FETCH edge; changes during other states are ignored.
- `zero` is consumed by the datapath in the BEQ EXEC cycle; the controller does not register it.
- Reset asserted mid-instruction: the next state is FETCH and any pending strobe is suppressed.

## Configuration
- `MULTICYCLE_CTRL_MEMWAIT_EN` defined:
  - MEM holds while `mem_ready`=0, keeping `memread`/`memwrite` asserted.
  - It exits on the first cycle `mem_ready`=1.
  - `pcwrite` (SW) and the WB transition (LW) wait for that cycle.
- Undefined: MEM is always one cycle and `mem_ready` is ignored.

## Structure
- `cpu_pkg`: opcode enum, alucontrol constants, state enum (FETCH, DECODE, EXEC, MEM, WB), instruction field positions.
- Sub-module `alu_decoder`: combinational funct/opcode → alucontrol plus an illegal-funct flag.

## Test plan
- ADDI `instr`=16'b1100_001_000_000001 after reset:
  - EXEC: `alusrc`=1, `alucontrol`=0000.
  - WB (cycle 4): `regwrite`=1, `regdst`=0, `pcwrite`=1.
- R-type SUB (funct 001): EXEC `regdst`=1, `alucontrol`=0001; `regwrite` pulses in cycle 4.
- LW then SW:
  - LW: `memread` in cycle 4, then `regwrite`+`memtoreg` in cycle 5.
  - SW: `memwrite`+`pcwrite` in cycle 4, with no `regwrite`.
  - With the macro and `mem_ready` low for 3 cycles, the strobe is held 4 cycles.
- BEQ: cycle 3 shows `branch`=1, `alucontrol`=0001, `pcwrite`=1; J: cycle 2 shows `jump`=1, `pcwrite`=1.
- Opcode 1111:
  - `illegal` rises in cycle 2 and stays high across a following legal ADDI.
  - Reset clears it.
- Reset asserted during LW MEM: the next cycle is FETCH with all outputs 0 and no `regwrite`.
